rev_serial_subtractor: RTL
==========================

# rev_serial_subtractor

Parametrised, multi-cycle two's-complement subtractor built from reversible gates. Each cycle it processes DIGIT bits: b is inverted through Feynman gates, and each bit uses a Peres-gate pair as a full adder with carry = r ^ s. It computes diff = a - b - bin over WIDTH/DIGIT cycles behind valid/ready handshakes. The borrow-in lets results be chained into wider words. It reports the same flag set as the combinational 4-bit subtractor (borrow, zero, parity, sign, overflow). It sits in the ALU datapath wherever width exceeds what a single-cycle reversible chain can close.

## Interface
- WIDTH, 8, operand and result width in bits; ≥ 2.
- DIGIT, 2, bits processed per cycle; WIDTH % DIGIT == 0; DIGIT == WIDTH gives a single-cycle core.
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset; asynchronous and active-high.
- in_valid  input  1  operands present.
- in_ready  output  1  block can accept operands; high only in IDLE.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- borrow_in  input  1  incoming borrow; used only when use_borrow_in = 1.
- use_borrow_in  input  1  1: compute a - b - borrow_in; 0: compute a - b.
- out_valid  output  1  result and flags valid.
- out_ready  input  1  consumer accepts the result.
- diff  output  WIDTH  difference, modulo 2^WIDTH.
- borrow  output  1  inverse of the final carry; 1 when unsigned a < b + bin.
- zero  output  1  diff == 0.
- parity  output  1  XOR of all diff bits.
- sign  output  1  diff[WIDTH-1].
- overflow  output  1  signed overflow: (a[MSB] ^ b[MSB]) & (a[MSB] ^ diff[MSB]), using the latched operands.

## Operation
- States:
  - IDLE: waits for operands.
  - RUN: CYCLES = WIDTH/DIGIT iterations, with a counter of clog2(CYCLES+1) bits.
  - DONE: presents the result.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready, latch a and b into shift registers and copy their MSBs for the overflow calculation.
  - Initialise carry = ~(use_borrow_in & borrow_in).
  - Clear the counter, clear the diff accumulator, go to RUN.
- RUN, every cycle:
  - Take the DIGIT LSBs of the a/b shift registers.
  - For each bit i: binv = b_i ^ 1 (Feynman gate); Peres 1 on (a_i, binv) gives q and r; Peres 2 on (q, carry) gives d_i and s; next carry = r ^ s.
  - Shift the DIGIT result bits into the accumulator MSB-first, so after the last cycle diff is correctly aligned.
  - Increment the counter; when it reaches CYCLES, register the flags and go to DONE.
- Flag computation on entry to DONE:
  - borrow = ~carry_out.
  - zero, parity and sign from the final diff.
  - overflow from the latched MSBs and diff[MSB].
- DONE:
  - out_valid = 1; diff and flags are held stable.
  - in_valid is ignored (in_ready = 0).
  - On out_ready, go to IDLE; out_valid drops on the next cycle.
- Chaining words: feed the borrow of the low word into borrow_in of the high word with use_borrow_in = 1. zero describes the current word only.
- Inputs a, b, borrow_in and use_borrow_in are sampled only on the accept edge. Changes to them during RUN or DONE have no effect.

## Timing
- Reset (asynchronous, any state including mid-RUN):
  - State goes to IDLE.
  - out_valid = 0, diff = 0, and all flags = 0.
  - in_ready = 1, both during reset and after it.
  - A partially computed result is discarded; no out_valid pulse is produced.
- Latency: operands accepted at edge k; out_valid rises after edge k + CYCLES.
- Throughput: one result per CYCLES + 2 cycles when out_ready is held high (accept, CYCLES × RUN, DONE, then back to IDLE).
- DIGIT == WIDTH: RUN lasts one cycle, so out_valid rises after edge k + 1.
- Backpressure: with out_ready low, DONE is held indefinitely with all outputs constant.
- No pipelining: a new accept is never possible in the same cycle as out_valid.

## Test plan
- WIDTH=8, DIGIT=2, use_borrow_in=0, a=0x35, b=0x12:
  - Response: out_valid rises exactly 4 cycles after accept.
  - diff=0x23, borrow=0, zero=0, parity=1, sign=0, overflow=0.
- a=0x12, b=0x35:
  - diff=0xDD, borrow=1, sign=1, parity=0, overflow=0.
- a=0x80, b=0x01:
  - diff=0x7F, borrow=0, overflow=1, sign=0, parity=1.
- Equal operands and borrow chaining:
  - a=b=0x5A gives diff=0x00, zero=1, parity=0, borrow=0.
  - a=b=0x00 with use_borrow_in=1, borrow_in=1 gives diff=0xFF, borrow=1.
- Handshake and backpressure:
  - Hold out_ready=0 for 3 cycles in DONE while driving new in_valid and changing a/b.
  - Outputs stay constant and in_ready stays 0.
  - After out_ready, in_ready returns after 1 cycle.
- Reset and single-cycle configuration:
  - Assert rst during the 2nd RUN cycle: out_valid, diff and flags are 0 immediately, in_ready=1, and no stale result appears.
  - Rerun with WIDTH=8, DIGIT=8: 0x35 - 0x12 gives out_valid 1 cycle after accept with the same flags as the first scenario.

Source files
------------

// File: rtl/rev_serial_subtractor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : rev_serial_subtractor
// Description : Digit-serial a - b - bin built from Feynman/Peres reversible
//               gates, with valid/ready handshakes and result flags.
// Revision    : 1.0 - initial release
// ============================================================================
module rev_serial_subtractor #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    input  logic             use_borrow_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             zero,
    output logic             parity,
    output logic             sign,
    output logic             overflow
);

    localparam int             c_cycles = WIDTH / DIGIT;
    localparam int             c_cnt_w  = $clog2(c_cycles + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(c_cycles);

    localparam logic [1:0] c_s_idle = 2'd0;
    localparam logic [1:0] c_s_run  = 2'd1;
    localparam logic [1:0] c_s_done = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic [WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]   r_b_sh;
    logic [WIDTH-1:0]   r_acc;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_carry;
    logic               r_a_msb;
    logic               r_b_msb;
    logic [WIDTH-1:0]   r_diff;
    logic               r_borrow;
    logic               r_zero;
    logic               r_parity;
    logic               r_sign;
    logic               r_overflow;

    logic               w_accept;
    logic               w_last;
    logic [DIGIT-1:0]   w_digit;
    logic               w_carry_out;
    logic [WIDTH-1:0]   w_acc_next;
    logic               w_c;
    logic               w_binv;
    logic               w_q;
    logic               w_r;
    logic               w_s;

    // ---------------- state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_s_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    assign w_accept = (r_state == c_s_idle) && in_valid;
    assign w_last   = ((r_cnt + c_cnt_w'(1)) == c_cnt_last);

    // ---------------- next-state logic ----------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_s_idle: if (in_valid)  w_state_next = c_s_run;
            c_s_run:  if (w_last)    w_state_next = c_s_done;
            c_s_done: if (out_ready) w_state_next = c_s_idle;
            default:                 w_state_next = c_s_idle;
        endcase
    end

    // ---------------- output logic ----------------
    always_comb begin
        in_ready  = (r_state == c_s_idle);
        out_valid = (r_state == c_s_done);
        diff      = r_diff;
        borrow    = r_borrow;
        zero      = r_zero;
        parity    = r_parity;
        sign      = r_sign;
        overflow  = r_overflow;
    end

    // Per bit: Feynman inverts b, Peres pair forms the full adder, carry = r ^ s.
    always_comb begin
        w_c     = r_carry;
        w_digit = '0;
        w_binv  = 1'b0;
        w_q     = 1'b0;
        w_r     = 1'b0;
        w_s     = 1'b0;
        for (int i = 0; i < DIGIT; i++) begin
            w_binv     = r_b_sh[i] ^ 1'b1;
            w_q        = r_a_sh[i] ^ w_binv;
            w_r        = r_a_sh[i] & w_binv;
            w_digit[i] = w_q ^ w_c;
            w_s        = w_q & w_c;
            w_c        = w_r ^ w_s;
        end
        w_carry_out = w_c;
    end

    // New digit enters at the top so the first digit ends up at bit 0.
    assign w_acc_next = WIDTH'({w_digit, r_acc} >> DIGIT);

    // ---------------- datapath ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_sh     <= '0;
            r_b_sh     <= '0;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_carry    <= 1'b0;
            r_a_msb    <= 1'b0;
            r_b_msb    <= 1'b0;
            r_diff     <= '0;
            r_borrow   <= 1'b0;
            r_zero     <= 1'b0;
            r_parity   <= 1'b0;
            r_sign     <= 1'b0;
            r_overflow <= 1'b0;
        end else if (w_accept) begin
            r_a_sh  <= a;
            r_b_sh  <= b;
            r_a_msb <= a[WIDTH-1];
            r_b_msb <= b[WIDTH-1];
            r_carry <= ~(use_borrow_in & borrow_in);
            r_cnt   <= '0;
            r_acc   <= '0;
        end else if (r_state == c_s_run) begin
            r_a_sh  <= r_a_sh >> DIGIT;
            r_b_sh  <= r_b_sh >> DIGIT;
            r_carry <= w_carry_out;
            r_acc   <= w_acc_next;
            r_cnt   <= r_cnt + c_cnt_w'(1);
            if (w_last) begin
                r_diff     <= w_acc_next;
                r_borrow   <= ~w_carry_out;
                r_zero     <= ~|w_acc_next;
                r_parity   <= ^w_acc_next;
                r_sign     <= w_acc_next[WIDTH-1];
                r_overflow <= (r_a_msb ^ r_b_msb) & (r_a_msb ^ w_acc_next[WIDTH-1]);
            end
        end
    end

endmodule
`default_nettype wire
